// File: rtl/mvm_uart_pkg.sv
// Shared MVM UART system constants: matrix geometry, bus widths and byte-count helper.
package mvm_uart_pkg;
  localparam int R   = 8;
  localparam int C   = 8;
  localparam int W_X = 8;
  localparam int W_K = 8;

  localparam int W_BUS_KX = R * C * W_K + C * W_X;
  localparam int W_BUS_Y  = R * (W_X + W_K + $clog2(C));

  function automatic int ceil_div(input int num, input int den);
    return (num + den - 1) / den;
  endfunction
endpackage

// File: rtl/mvm_uart_host_uart_byte_sampler.sv
// UART receive sampler: 2-FF synchronizer, start validation at half-bit, mid-bit data and stop sampling.
module uart_byte_sampler
  import mvm_uart_pkg::*;
#(
  parameter int CLOCKS_PER_PULSE = 200_000_000 / 9600,
  parameter int BITS_PER_WORD    = 8
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     rx,
  output logic                     byte_valid,
  output logic [BITS_PER_WORD-1:0] byte_data,
  output logic                     frame_err
);
  localparam int CW = (CLOCKS_PER_PULSE > 1) ? $clog2(CLOCKS_PER_PULSE) : 1;
  localparam int BW = (BITS_PER_WORD > 1) ? $clog2(BITS_PER_WORD) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLOCKS_PER_PULSE - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLOCKS_PER_PULSE / 2 - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(BITS_PER_WORD - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic          rx_p0, rx_p1, rx_p2;
  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [BW-1:0] bit_idx;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      {rx_p0, rx_p1, rx_p2} <= 3'b111;
      state      <= S_IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      rx_p0      <= rx;
      rx_p1      <= rx_p0;
      rx_p2      <= rx_p1;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (rx_p2 && !rx_p1) begin
            state <= S_START;
            cnt   <= '0;
          end
        end
        S_START: begin
          // A line that is high again at half-bit was a glitch, not a start bit.
          if (cnt == CNT_HALF) begin
            cnt     <= '0;
            bit_idx <= '0;
            state   <= rx_p1 ? S_IDLE : S_DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (cnt == CNT_LAST) begin
            cnt <= '0;
            if (bit_idx == BIT_LAST) state <= S_STOP;
            else bit_idx <= bit_idx + 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          if (cnt == CNT_LAST) begin
            cnt   <= '0;
            state <= S_IDLE;
            if (rx_p1) byte_valid <= 1'b1;
            else       frame_err  <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state == S_DATA && cnt == CNT_LAST)
      byte_data <= {rx_p1, byte_data[BITS_PER_WORD-1:1]};
  end
endmodule

// File: rtl/mvm_uart_host.sv
// Host side of the MVM UART link: serializes one wide K/X word onto tx, reassembles Y words from rx.
module mvm_uart_host
  import mvm_uart_pkg::*;
#(
  parameter int CLOCKS_PER_PULSE = 200_000_000 / 9600,
  parameter int BITS_PER_WORD    = 8,
  parameter int TX_STOP_BITS     = 1,
  parameter int W_TX             = W_BUS_KX,
  parameter int W_RX             = W_BUS_Y
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            s_valid,
  output logic            s_ready,
  input  logic [W_TX-1:0] s_data,
  output logic            tx,
  input  logic            rx,
  output logic            m_valid,
  input  logic            m_ready,
  output logic [W_RX-1:0] m_data,
  output logic            frame_err,
  output logic            overrun
);
  localparam int N_TX = ceil_div(W_TX, BITS_PER_WORD);
  localparam int N_RX = ceil_div(W_RX, BITS_PER_WORD);
  localparam int SHW  = N_TX * BITS_PER_WORD;
  localparam int ASW  = (N_RX - 1) * BITS_PER_WORD;
  localparam int CW   = (CLOCKS_PER_PULSE > 1) ? $clog2(CLOCKS_PER_PULSE) : 1;
  localparam int BW   = (BITS_PER_WORD > 1) ? $clog2(BITS_PER_WORD) : 1;
  localparam int SW   = (TX_STOP_BITS > 1) ? $clog2(TX_STOP_BITS) : 1;
  localparam int TBW  = (N_TX > 1) ? $clog2(N_TX) : 1;
  localparam int RBW  = (N_RX > 1) ? $clog2(N_RX) : 1;

  localparam logic [CW-1:0]  CNT_LAST     = CW'(CLOCKS_PER_PULSE - 1);
  localparam logic [BW-1:0]  BIT_LAST     = BW'(BITS_PER_WORD - 1);
  localparam logic [SW-1:0]  STOP_LAST    = SW'(TX_STOP_BITS - 1);
  localparam logic [TBW-1:0] TX_BYTE_LAST = TBW'(N_TX - 1);
  localparam logic [RBW-1:0] RX_BYTE_LAST = RBW'(N_RX - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic [1:0]     tx_state;
  logic [CW-1:0]  tx_cnt;
  logic [BW-1:0]  tx_bit;
  logic [SW-1:0]  tx_stop;
  logic [TBW-1:0] tx_byte;
  logic [SHW-1:0] tx_sh;

  assign s_ready = (tx_state == S_IDLE);

  // tx is registered and updated on the same edges as the FSM so the line never glitches.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tx_state <= S_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_stop  <= '0;
      tx_byte  <= '0;
      tx       <= 1'b1;
    end else begin
      case (tx_state)
        S_IDLE: begin
          if (s_valid) begin
            tx_state <= S_START;
            tx_cnt   <= '0;
            tx_byte  <= '0;
            tx       <= 1'b0;
          end
        end
        S_START: begin
          if (tx_cnt == CNT_LAST) begin
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_state <= S_DATA;
            tx       <= tx_sh[0];
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (tx_cnt == CNT_LAST) begin
            tx_cnt <= '0;
            if (tx_bit == BIT_LAST) begin
              tx_state <= S_STOP;
              tx_stop  <= '0;
              tx       <= 1'b1;
            end else begin
              tx_bit <= tx_bit + 1'b1;
              tx     <= tx_sh[1];
            end
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        default: begin
          if (tx_cnt == CNT_LAST) begin
            tx_cnt <= '0;
            if (tx_stop == STOP_LAST) begin
              if (tx_byte == TX_BYTE_LAST) begin
                tx_state <= S_IDLE;
              end else begin
                tx_byte  <= tx_byte + 1'b1;
                tx_state <= S_START;
                tx       <= 1'b0;
              end
            end else begin
              tx_stop <= tx_stop + 1'b1;
            end
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (tx_state == S_IDLE && s_valid)
      tx_sh <= SHW'(s_data);
    else if (tx_state == S_DATA && tx_cnt == CNT_LAST)
      tx_sh <= tx_sh >> 1;
  end

  logic                     byte_valid;
  logic [BITS_PER_WORD-1:0] byte_data;
  logic [RBW-1:0]           byte_cnt;
  logic [ASW-1:0]           asm_q;

  uart_byte_sampler #(
    .CLOCKS_PER_PULSE(CLOCKS_PER_PULSE),
    .BITS_PER_WORD   (BITS_PER_WORD)
  ) u_sampler (
    .clk       (clk),
    .rstn      (rstn),
    .rx        (rx),
    .byte_valid(byte_valid),
    .byte_data (byte_data),
    .frame_err (frame_err)
  );

  // The final byte bypasses asm_q and is merged directly into m_data.
  always_ff @(posedge clk) begin
    if (byte_valid && byte_cnt != RX_BYTE_LAST)
      asm_q[int'(byte_cnt) * BITS_PER_WORD +: BITS_PER_WORD] <= byte_data;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      byte_cnt <= '0;
      m_valid  <= 1'b0;
      m_data   <= '0;
      overrun  <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (m_valid && m_ready) m_valid <= 1'b0;
      if (byte_valid) begin
        if (byte_cnt == RX_BYTE_LAST) begin
          byte_cnt <= '0;
          if (!m_valid || m_ready) begin
            m_data  <= W_RX'({byte_data, asm_q});
            m_valid <= 1'b1;
          end else begin
            overrun <= 1'b1;
          end
        end else begin
          byte_cnt <= byte_cnt + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_mvm_uart_host.sv
// Scoreboarded bench for mvm_uart_host: TX waveform, RX assembly, errors, overrun and loopback.
module tb_mvm_uart_host;
  localparam int CPP = 4;

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic        s_valid, s_ready, tx, rx_line, m_valid, m_ready, frame_err, overrun;
  logic [15:0] s_data;
  logic [11:0] m_data;

  logic        lb_s_valid, lb_s_ready, lb_tx, lb_m_valid, lb_m_ready, lb_frame_err, lb_overrun;
  logic [15:0] lb_s_data, lb_m_data;

  always #5 clk = ~clk;

  mvm_uart_host #(.CLOCKS_PER_PULSE(CPP), .BITS_PER_WORD(8), .TX_STOP_BITS(1),
                  .W_TX(16), .W_RX(12)) dut (
    .clk(clk), .rstn(rstn), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .tx(tx), .rx(rx_line), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .frame_err(frame_err), .overrun(overrun));

  mvm_uart_host #(.CLOCKS_PER_PULSE(CPP), .BITS_PER_WORD(8), .TX_STOP_BITS(1),
                  .W_TX(16), .W_RX(16)) lb (
    .clk(clk), .rstn(rstn), .s_valid(lb_s_valid), .s_ready(lb_s_ready), .s_data(lb_s_data),
    .tx(lb_tx), .rx(lb_tx), .m_valid(lb_m_valid), .m_ready(lb_m_ready), .m_data(lb_m_data),
    .frame_err(lb_frame_err), .overrun(lb_overrun));

  int n_cmp = 0, n_err = 0;
  int fe_cnt = 0, ov_cnt = 0, lb_err_cnt = 0;
  logic [11:0] exp_q[$];
  logic [15:0] lb_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic exp_bit(input logic [15:0] w, input int k);
    int byt, pos;
    byt = k / 10;
    pos = k % 10;
    if (pos == 0) return 1'b0;
    if (pos == 9) return 1'b1;
    return w[byt * 8 + pos - 1];
  endfunction

  always @(negedge clk) begin
    if (frame_err) fe_cnt++;
    if (overrun) ov_cnt++;
    if (lb_frame_err || lb_overrun) lb_err_cnt++;
    if (m_valid && m_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL m_unexpected: got %0h expected no word", m_data);
      end else check("m_data", {20'h0, m_data}, {20'h0, exp_q.pop_front()});
    end
    if (lb_m_valid && lb_m_ready) begin
      if (lb_q.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL lb_unexpected: got %0h expected no word", lb_m_data);
      end else check("lb_m_data", {16'h0, lb_m_data}, {16'h0, lb_q.pop_front()});
    end
  end

  // Sends a word and checks every tx cycle plus the exact s_ready return time.
  task automatic tx_word(input logic [15:0] w);
    int guard = 0;
    @(negedge clk);
    while (!s_ready && guard < 400) begin @(negedge clk); guard++; end
    check("s_ready_wait", {31'h0, s_ready}, 32'h1);
    s_data = w; s_valid = 1'b1;
    @(posedge clk); #1 s_valid = 1'b0;
    for (int k = 0; k < 20; k++)
      for (int c = 0; c < CPP; c++) begin
        @(negedge clk);
        check($sformatf("tx_bit%0d", k), {31'h0, tx}, {31'h0, exp_bit(w, k)});
      end
    check("s_ready_at_79", {31'h0, s_ready}, 32'h0);
    @(negedge clk);
    check("s_ready_at_80", {31'h0, s_ready}, 32'h1);
  endtask

  task automatic bit_time(input logic v, input int n);
    rx_line = v;
    repeat (CPP * n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int stops, input logic stop_val);
    bit_time(1'b0, 1);
    for (int i = 0; i < 8; i++) bit_time(b[i], 1);
    bit_time(stop_val, stops);
    rx_line = 1'b1;
  endtask

  task automatic send_pair(input logic [7:0] b0, input logic [7:0] b1, input int stops);
    send_byte(b0, stops, 1'b1);
    send_byte(b1, stops, 1'b1);
  endtask

  task automatic wait_mvalid();
    int guard = 0;
    while (!m_valid && guard < 200) begin @(negedge clk); guard++; end
    check("m_valid_wait", {31'h0, m_valid}, 32'h1);
  endtask

  task automatic drain();
    int guard = 0;
    while (exp_q.size() != 0 && guard < 300) begin @(negedge clk); guard++; end
    check("scoreboard_drain", exp_q.size(), 0);
  endtask

  typedef struct {
    logic [15:0] s_word;
    logic [7:0]  b0;
    logic [7:0]  b1;
    int          stops;
  } vec_t;

  vec_t vecs[4];

  initial begin
    logic [15:0] pair16;
    int          fe0, ov0, guard;
    vecs[0] = '{16'hA53C, 8'h11, 8'h07, 1};
    vecs[1] = '{16'h0000, 8'hFF, 8'hFF, 1};
    vecs[2] = '{16'hFFFF, 8'h00, 8'h00, 2};
    vecs[3] = '{16'h1234, 8'h5A, 8'hC3, 3};

    s_valid = 1'b0; s_data = '0; rx_line = 1'b1; m_ready = 1'b1;
    lb_s_valid = 1'b0; lb_s_data = '0; lb_m_ready = 1'b1;
    #1 rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx", {31'h0, tx}, 32'h1);
    check("rst_s_ready", {31'h0, s_ready}, 32'h1);
    check("rst_m_valid", {31'h0, m_valid}, 32'h0);
    check("rst_m_data", {20'h0, m_data}, 32'h0);
    check("rst_frame_err", {31'h0, frame_err}, 32'h0);
    check("rst_overrun", {31'h0, overrun}, 32'h0);
    rstn = 1'b1;
    @(posedge clk); #1;

    // Reset in the middle of a TX word while an RX word is pending.
    m_ready = 1'b0;
    send_pair(8'h34, 8'h02, 1);
    wait_mvalid();
    @(negedge clk);
    s_data = 16'hFFFF; s_valid = 1'b1;
    @(posedge clk); #1 s_valid = 1'b0;
    repeat (10) @(posedge clk);
    #2 rstn = 1'b0;
    #1;
    check("midrst_tx", {31'h0, tx}, 32'h1);
    check("midrst_s_ready", {31'h0, s_ready}, 32'h1);
    check("midrst_m_valid", {31'h0, m_valid}, 32'h0);
    check("midrst_m_data", {20'h0, m_data}, 32'h0);
    @(posedge clk); #1 rstn = 1'b1; m_ready = 1'b1;
    tx_word(16'h5AC3);

    // Table: TX word and RX pair in parallel.
    for (int i = 0; i < 4; i++) begin
      pair16 = {vecs[i].b1, vecs[i].b0};
      exp_q.push_back(pair16[11:0]);
      @(posedge clk); #1;
      fork
        tx_word(vecs[i].s_word);
        send_pair(vecs[i].b0, vecs[i].b1, vecs[i].stops);
      join
      drain();
    end

    // Word held until m_ready.
    m_ready = 1'b0;
    exp_q.push_back(12'hABC);
    @(posedge clk); #1;
    send_pair(8'hBC, 8'h0A, 3);
    wait_mvalid();
    check("held_m_data", {20'h0, m_data}, 32'hABC);
    repeat (5) @(negedge clk);
    check("held_m_valid", {31'h0, m_valid}, 32'h1);
    @(posedge clk); #1 m_ready = 1'b1;
    @(posedge clk); #1;
    check("m_valid_cleared", {31'h0, m_valid}, 32'h0);
    check("held_popped", exp_q.size(), 0);

    // Bad stop bit, then a one-cycle glitch, then a good pair.
    fe0 = fe_cnt;
    send_byte(8'h55, 1, 1'b0);
    bit_time(1'b1, 2);
    repeat (4) @(posedge clk);
    #1;
    check("frame_err_pulses", fe_cnt - fe0, 1);
    rx_line = 1'b0;
    @(posedge clk); #1 rx_line = 1'b1;
    repeat (3 * CPP) @(posedge clk);
    #1;
    check("glitch_no_frame_err", fe_cnt - fe0, 1);
    check("glitch_no_word", {31'h0, m_valid}, 32'h0);
    exp_q.push_back(12'hF21);
    send_pair(8'h21, 8'h0F, 1);
    drain();

    // Overrun: second word dropped, first held.
    m_ready = 1'b0;
    ov0 = ov_cnt;
    exp_q.push_back(12'h765);
    @(posedge clk); #1;
    send_pair(8'h65, 8'h07, 1);
    send_pair(8'h98, 8'h0B, 1);
    repeat (10) @(posedge clk);
    #1;
    check("overrun_pulses", ov_cnt - ov0, 1);
    check("overrun_m_valid", {31'h0, m_valid}, 32'h1);
    check("overrun_m_data", {20'h0, m_data}, 32'h765);
    m_ready = 1'b1;
    drain();

    // Loopback: back-to-back random words, TX of the next overlapping RX of the previous.
    for (int i = 0; i < 5; i++) begin
      guard = 0;
      @(negedge clk);
      while (!lb_s_ready && guard < 400) begin @(negedge clk); guard++; end
      check("lb_s_ready_wait", {31'h0, lb_s_ready}, 32'h1);
      lb_s_data = 16'($urandom);
      lb_s_valid = 1'b1;
      lb_q.push_back(lb_s_data);
      @(posedge clk); #1 lb_s_valid = 1'b0;
    end
    guard = 0;
    while (lb_q.size() != 0 && guard < 400) begin @(negedge clk); guard++; end
    check("lb_drain", lb_q.size(), 0);
    check("lb_no_errors", lb_err_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got no finish expected finish before 1ms");
    $fatal(1, "timeout");
  end
endmodule
